// File: rtl/symbol_mapper_pkg.sv
// ============================================================================
// symbol_mapper_pkg : shared FSM encodings, amplitude constant, bit mapping
// Revision: 1.0
// ============================================================================
`default_nettype none

package symbol_mapper_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } state_t;

    localparam logic [15:0] AMP_POS = 16'h5A82;

    // Bit 1 -> +amp, bit 0 -> two's complement negation of amp.
    function automatic logic [15:0] map_bit(input logic b, input logic [15:0] amp);
        return b ? amp : (~amp + 16'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/symbol_mapper_if.sv
// ============================================================================
// symbol_mapper_if : bit input handshake and FIR-facing sample outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface symbol_mapper_if;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [15:0] symb_out;
    logic        read_ready;
    logic        busy;
    logic        underrun;

    modport master (
        output bit_in, bit_valid,
        input  bit_ready, symb_out, read_ready, busy, underrun
    );

    modport slave (
        input  bit_in, bit_valid,
        output bit_ready, symb_out, read_ready, busy, underrun
    );
endinterface

`default_nettype wire

// File: rtl/symbol_mapper_bit_fifo.sv
// ============================================================================
// bit_fifo : 1-bit wide FIFO, pointers carry an extra wrap bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_fifo #(
    parameter int DEPTH = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic push,
    input  wire logic pop,
    input  wire logic din,
    output logic      dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/symbol_mapper.sv
// ============================================================================
// symbol_mapper : buffers bits, maps to +/-AMP BPSK, upsamples by SPS.
// Optional preamble insertion compiled in with macro PREAMBLE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module symbol_mapper
    import symbol_mapper_pkg::*;
#(
    parameter int          SPS          = 4,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] AMP          = AMP_POS
`ifdef PREAMBLE_EN
    ,
    parameter int          PREAMBLE_LEN = 8,
    parameter logic [15:0] PREAMBLE_PAT = 16'hAAAA
`endif
) (
    input  wire logic       clk,
    input  wire logic       reset,
    symbol_mapper_if.slave  bus
);
    localparam int PW = $clog2(SPS);

    logic [PW-1:0] phase_q;
    state_t        state_q, state_d;
    logic [15:0]   symb_q, symb_d;
    logic          rr_q, rr_d;
    logic          und_q, und_d;
    logic          w_decision;
    logic          w_push;
    logic          w_pop;
    logic          w_do_data;
    logic          w_fifo_dout;
    logic          w_fifo_full;
    logic          w_fifo_empty;
`ifdef PREAMBLE_EN
    logic [4:0]    cnt_q, cnt_d;
    logic [3:0]    w_pre_idx;

    assign w_pre_idx = 4'(5'd15 - cnt_q);
`endif

    assign w_decision     = (phase_q == PW'(SPS - 1));
    assign w_push         = bus.bit_valid & bus.bit_ready;
    assign bus.bit_ready  = ~w_fifo_full & reset;
    assign bus.symb_out   = symb_q;
    assign bus.read_ready = rr_q;
    assign bus.underrun   = und_q;
    assign bus.busy       = (state_q != IDLE) | ~w_fifo_empty;

    bit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.bit_in),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
            state_q <= IDLE;
            symb_q  <= '0;
            rr_q    <= 1'b0;
            und_q   <= 1'b0;
`ifdef PREAMBLE_EN
            cnt_q   <= '0;
`endif
        end else begin
            phase_q <= w_decision ? '0 : phase_q + 1'b1;
            state_q <= state_d;
            symb_q  <= symb_d;
            rr_q    <= rr_d;
            und_q   <= und_d;
`ifdef PREAMBLE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Off-decision edges leave the defaults: zero sample, no strobe.
    always_comb begin
        state_d   = state_q;
        symb_d    = '0;
        rr_d      = 1'b0;
        und_d     = 1'b0;
        w_pop     = 1'b0;
        w_do_data = 1'b0;
`ifdef PREAMBLE_EN
        cnt_d     = cnt_q;
`endif
        if (w_decision) begin
            case (state_q)
                IDLE: begin
                    if (!w_fifo_empty) begin
`ifdef PREAMBLE_EN
                        symb_d  = map_bit(PREAMBLE_PAT[15], AMP);
                        rr_d    = 1'b1;
                        cnt_d   = 5'd1;
                        state_d = PREAMBLE;
`else
                        w_do_data = 1'b1;
`endif
                    end
                end
`ifdef PREAMBLE_EN
                PREAMBLE: begin
                    if (cnt_q < 5'(PREAMBLE_LEN)) begin
                        symb_d = map_bit(PREAMBLE_PAT[w_pre_idx], AMP);
                        rr_d   = 1'b1;
                        cnt_d  = cnt_q + 5'd1;
                    end else begin
                        w_do_data = 1'b1;
                    end
                end
`endif
                DATA:    w_do_data = 1'b1;
                default: state_d = IDLE;
            endcase

            // The last preamble step falls through into the data action on the same edge.
            if (w_do_data) begin
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    symb_d  = map_bit(w_fifo_dout, AMP);
                    rr_d    = 1'b1;
                    state_d = DATA;
                end else begin
                    und_d   = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

endmodule

`default_nettype wire
